game_flow_controller: RTL and testbench
=======================================

GAME_FLOW_CONTROLLER -- requirements
Module: game_flow_controller

Interface
REQ-001 Parameter DEATH_FRAMES, default 60, frames the game stays frozen after a death (1..255).
REQ-002 Parameter DOOR_FRAMES, default 30, consecutive frames both players must stand at their doors to win (1..255).
REQ-003 Parameter LIVES, default 3, lives loaded at game start (1..3).
REQ-004 Clk  in  1  system clock; all state changes on its rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 frame_tick  in  1  one-Clk pulse per video frame.
REQ-007 start  in  1  start/restart key, level, asynchronous to game.
REQ-008 p1_dead, p2_dead  in  1 each  OR-ed hazard death flags, latched upstream until hazard_reset.
REQ-009 p1_at_door, p2_at_door  in  1 each  player overlaps own exit door.
REQ-010 hazard_reset  out  1  one-cycle clear pulse to all hazard controllers.
REQ-011 players_frozen  out  1  1 = player motion disabled.
REQ-012 state  out  3  IDLE=0, ARM=1, PLAY=2, DYING=3, OVER=4, WIN=5.
REQ-013 lives  out  2  remaining lives.
REQ-014 dead_who  out  2  {p2,p1} death flags captured at last death.

Function
REQ-015 start SHALL be registered once; start_pulse = start & ~start_q; only start_pulse is used by the FSM.
REQ-016 IDLE: players_frozen=1; start_pulse SHALL load lives=LIVES, clear dead_who, go to ARM.
REQ-017 ARM: hazard_reset=1 for exactly this one cycle, players_frozen=1, frame counter and door counter cleared; next cycle PLAY unconditionally.
REQ-018 hazard_reset SHALL be 0 in every state other than ARM.
REQ-019 PLAY: players_frozen=0; if p1_dead|p2_dead, next state DYING, dead_who<={p2_dead,p1_dead}, lives<=lives-1 saturating at 0, frame counter cleared.
REQ-020 PLAY door rule: on frame_tick with p1_at_door&p2_at_door the 8-bit door counter increments; any cycle with either deasserted clears it to 0; a tick that brings it to DOOR_FRAMES SHALL move to WIN.
REQ-021 Death in the same cycle as the winning door tick SHALL take priority: DYING, not WIN.
REQ-022 DYING: players_frozen=1; dead inputs and door inputs ignored; frame counter increments on frame_tick; on the tick where counter equals DEATH_FRAMES-1, next state OVER if lives==0, else ARM (lives unchanged).
REQ-023 OVER and WIN: players_frozen=1; start_pulse SHALL go to IDLE; all other inputs ignored.
REQ-024 start_pulse in ARM, PLAY or DYING SHALL be ignored.
REQ-025 Counters SHALL never wrap; they are only compared against parameters not exceeding 255.
REQ-026 All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.

Reset
REQ-027 Reset SHALL, on the next rising Clk, force state=IDLE, hazard_reset=0, players_frozen=1, lives=0, dead_who=0, both counters=0, start_q=0, from any state including mid-DYING.
REQ-028 Reset has priority over every other input in the same cycle.
REQ-029 A start held high through Reset deassertion SHALL produce a start_pulse in the first cycle after reset (start_q cleared).

Verification
REQ-030 Reset, pulse start -> ARM one cycle with hazard_reset=1, then PLAY, lives=3, players_frozen=0.
REQ-031 In PLAY assert p2_dead -> DYING next cycle, dead_who=2'b10, lives=2; after 60 frame_ticks -> ARM with one hazard_reset pulse, then PLAY.
REQ-032 Three successive deaths -> lives=0, after third DYING period state=OVER; start pulse -> IDLE; second pulse -> ARM, lives=3.
REQ-033 Both at door for 29 ticks, drop p1_at_door one cycle, then 30 ticks -> WIN only after the 30th tick of the second run.
REQ-034 p1_dead asserted on the same cycle as the 30th door tick -> DYING, not WIN, lives decremented.
REQ-035 Reset asserted mid-DYING (frame 20) -> IDLE next cycle, all outputs at reset values, held start does not re-trigger until released and re-pressed.

Source files
------------

// File: rtl/game_flow_controller_if.sv
// -----------------------------------------------------------------------------
// game_flow_controller_if
// Groups the game-flow controller's per-frame inputs and status outputs.
//   frame_tick     : one-Clk pulse per video frame
//   start          : start/restart key level (asynchronous to the game)
//   p1/p2_dead     : latched hazard death flags
//   p1/p2_at_door  : player overlaps own exit door
//   hazard_reset   : one-cycle clear pulse to hazard controllers
//   players_frozen : 1 = player motion disabled
//   state          : IDLE=0 ARM=1 PLAY=2 DYING=3 OVER=4 WIN=5
//   lives          : remaining lives
//   dead_who       : {p2,p1} death flags captured at the last death
// master : game side (drives inputs, observes status)
// slave  : the controller
// -----------------------------------------------------------------------------
interface game_flow_controller_if;
  logic       frame_tick;
  logic       start;
  logic       p1_dead;
  logic       p2_dead;
  logic       p1_at_door;
  logic       p2_at_door;
  logic       hazard_reset;
  logic       players_frozen;
  logic [2:0] state;
  logic [1:0] lives;
  logic [1:0] dead_who;

  modport master (
    output frame_tick, start, p1_dead, p2_dead, p1_at_door, p2_at_door,
    input  hazard_reset, players_frozen, state, lives, dead_who
  );

  modport slave (
    input  frame_tick, start, p1_dead, p2_dead, p1_at_door, p2_at_door,
    output hazard_reset, players_frozen, state, lives, dead_who
  );
endinterface

// File: rtl/game_flow_controller.sv
// -----------------------------------------------------------------------------
// game_flow_controller
// Top-level game sequencing: start, arm (hazard clear), play, death freeze,
// game over and level win.
// Ports:
//   Clk   : system clock, all state changes on rising edge
//   Reset : synchronous, active-high reset
//   gf    : game_flow_controller_if.slave (frame/start/death/door inputs,
//           hazard_reset/players_frozen/state/lives/dead_who outputs)
// Parameters:
//   DEATH_FRAMES : frames frozen after a death (1..255)
//   DOOR_FRAMES  : consecutive both-at-door frames needed to win (1..255)
//   LIVES        : lives loaded at game start (1..3)
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module game_flow_controller #(
  parameter int unsigned DEATH_FRAMES = 60,
  parameter int unsigned DOOR_FRAMES  = 30,
  parameter int unsigned LIVES        = 3
) (
  input  logic                   Clk,
  input  logic                   Reset,
  game_flow_controller_if.slave  gf
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_PLAY  = 3'd2,
    S_DYING = 3'd3,
    S_OVER  = 3'd4,
    S_WIN   = 3'd5
  } state_e;

  localparam logic [7:0] DEATH_LAST  = 8'(DEATH_FRAMES - 1);
  localparam logic [8:0] DOOR_TARGET = 9'(DOOR_FRAMES);
  localparam logic [1:0] LIVES_INIT  = 2'(LIVES);

  state_e     state_q, state_d;
  logic       start_q, start_d;
  logic [1:0] lives_q, lives_d;
  logic [1:0] dead_who_q, dead_who_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [7:0] door_cnt_q, door_cnt_d;
  logic       hazard_reset_q, hazard_reset_d;
  logic       players_frozen_q, players_frozen_d;

  logic       start_pulse;
  logic       any_dead;
  logic       both_at_door;
  logic [8:0] door_inc;
  logic [7:0] frame_inc;

  assign start_pulse  = gf.start & ~start_q;
  assign any_dead     = gf.p1_dead | gf.p2_dead;
  assign both_at_door = gf.p1_at_door & gf.p2_at_door;
  // 9-bit so the win compare is exact even with the counter at 255
  assign door_inc     = {1'b0, door_cnt_q} + 9'd1;
  assign frame_inc    = (frame_cnt_q == 8'hFF) ? frame_cnt_q : frame_cnt_q + 8'd1;

  // Next-state, counter and output-register computation
  always_comb begin
    state_d    = state_q;
    start_d    = gf.start;
    lives_d    = lives_q;
    dead_who_d = dead_who_q;
    frame_cnt_d = frame_cnt_q;
    door_cnt_d  = door_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start_pulse) begin
          lives_d    = LIVES_INIT;
          dead_who_d = 2'b00;
          state_d    = S_ARM;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ARM: begin
        frame_cnt_d = 8'd0;
        door_cnt_d  = 8'd0;
        state_d     = S_PLAY;
      end

      S_PLAY: begin
        // a death outranks a simultaneous winning door tick
        if (any_dead) begin
          state_d     = S_DYING;
          dead_who_d  = {gf.p2_dead, gf.p1_dead};
          lives_d     = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
          frame_cnt_d = 8'd0;
        end else if (!both_at_door) begin
          door_cnt_d = 8'd0;
        end else if (gf.frame_tick) begin
          door_cnt_d = door_inc[8] ? 8'hFF : door_inc[7:0];
          if (door_inc == DOOR_TARGET) begin
            state_d = S_WIN;
          end else begin
            state_d = S_PLAY;
          end
        end else begin
          door_cnt_d = door_cnt_q;
        end
      end

      S_DYING: begin
        if (gf.frame_tick) begin
          if (frame_cnt_q == DEATH_LAST) begin
            state_d = (lives_q == 2'd0) ? S_OVER : S_ARM;
          end else begin
            frame_cnt_d = frame_inc;
          end
        end else begin
          frame_cnt_d = frame_cnt_q;
        end
      end

      S_OVER, S_WIN: begin
        if (start_pulse) begin
          state_d = S_IDLE;
        end else begin
          state_d = state_q;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    hazard_reset_d   = (state_d == S_ARM);
    players_frozen_d = (state_d != S_PLAY);
  end

  // State, counter and output registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q          <= S_IDLE;
      start_q          <= 1'b0;
      lives_q          <= 2'd0;
      dead_who_q       <= 2'b00;
      frame_cnt_q      <= 8'd0;
      door_cnt_q       <= 8'd0;
      hazard_reset_q   <= 1'b0;
      players_frozen_q <= 1'b1;
    end else begin
      state_q          <= state_d;
      start_q          <= start_d;
      lives_q          <= lives_d;
      dead_who_q       <= dead_who_d;
      frame_cnt_q      <= frame_cnt_d;
      door_cnt_q       <= door_cnt_d;
      hazard_reset_q   <= hazard_reset_d;
      players_frozen_q <= players_frozen_d;
    end
  end

  assign gf.state          = state_q;
  assign gf.lives          = lives_q;
  assign gf.dead_who       = dead_who_q;
  assign gf.hazard_reset   = hazard_reset_q;
  assign gf.players_frozen = players_frozen_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// -----------------------------------------------------------------------------
// tb_game_flow_controller
// Directed bench for game_flow_controller with default parameters
// (DEATH_FRAMES=60, DOOR_FRAMES=30, LIVES=3). Observed outputs are packed as
// {state, hazard_reset, players_frozen, lives, dead_who} and compared with
// hand-computed values one cycle at a time, #1 after the rising edge.
// -----------------------------------------------------------------------------
module tb_game_flow_controller;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ARM   = 3'd1;
  localparam logic [2:0] PLAY  = 3'd2;
  localparam logic [2:0] DYING = 3'd3;
  localparam logic [2:0] OVER  = 3'd4;
  localparam logic [2:0] WIN   = 3'd5;

  logic Clk;
  logic Reset;
  int   n_cmp;
  int   n_err;
  logic [8:0] obs;
  logic [8:0] exp_v;

  game_flow_controller_if gf_if ();

  game_flow_controller dut (
    .Clk   (Clk),
    .Reset (Reset),
    .gf    (gf_if)
  );

  assign obs = {gf_if.state, gf_if.hazard_reset, gf_if.players_frozen,
                gf_if.lives, gf_if.dead_who};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // n frames: tick cycle followed by an idle cycle
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      gf_if.frame_tick = 1'b1;
      step();
      gf_if.frame_tick = 1'b0;
      step();
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    gf_if.frame_tick = 1'b0; gf_if.start = 1'b0;
    gf_if.p1_dead = 1'b0; gf_if.p2_dead = 1'b0;
    gf_if.p1_at_door = 1'b0; gf_if.p2_at_door = 1'b0;
    step(); step();
    exp_v = {IDLE, 1'b0, 1'b1, 2'd0, 2'b00};
    n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL reset_values: got %b expected %b", obs, exp_v); end
    Reset = 1'b0;
    step();
    n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL idle_after_reset: got %b expected %b", obs, exp_v); end
  endtask

  task automatic test_start();
    gf_if.start = 1'b1;
    step();
    exp_v = {ARM, 1'b1, 1'b1, 2'd3, 2'b00};
    n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL start_arm: got %b expected %b", obs, exp_v); end
    gf_if.start = 1'b0;
    step();
    exp_v = {PLAY, 1'b0, 1'b0, 2'd3, 2'b00};
    n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL start_play: got %b expected %b", obs, exp_v); end
  endtask

  task automatic test_death_p2();
    gf_if.p2_dead = 1'b1;
    step();
    exp_v = {DYING, 1'b0, 1'b1, 2'd2, 2'b10};
    n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL p2_death: got %b expected %b", obs, exp_v); end
    frames(30);
    gf_if.start = 1'b1; step(); gf_if.start = 1'b0; step();
    frames(29);
    n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL dying_59_ticks: got %b expected %b", obs, exp_v); end
    gf_if.frame_tick = 1'b1; step(); gf_if.frame_tick = 1'b0;
    exp_v = {ARM, 1'b1, 1'b1, 2'd2, 2'b10};
    n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL dying_to_arm: got %b expected %b", obs, exp_v); end
    gf_if.p2_dead = 1'b0;
    step();
    exp_v = {PLAY, 1'b0, 1'b0, 2'd2, 2'b10};
    n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL rearm_play: got %b expected %b", obs, exp_v); end
  endtask

  task automatic test_game_over();
    gf_if.p1_dead = 1'b1; step(); gf_if.p1_dead = 1'b0;
    exp_v = {DYING, 1'b0, 1'b1, 2'd1, 2'b01};
    n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL second_death: got %b expected %b", obs, exp_v); end
    frames(59);
    gf_if.frame_tick = 1'b1; step(); gf_if.frame_tick = 1'b0;
    step();
    exp_v = {PLAY, 1'b0, 1'b0, 2'd1, 2'b01};
    n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL second_replay: got %b expected %b", obs, exp_v); end
    gf_if.p1_dead = 1'b1; gf_if.p2_dead = 1'b1; step();
    gf_if.p1_dead = 1'b0; gf_if.p2_dead = 1'b0;
    exp_v = {DYING, 1'b0, 1'b1, 2'd0, 2'b11};
    n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL third_death: got %b expected %b", obs, exp_v); end
    frames(59);
    gf_if.frame_tick = 1'b1; step(); gf_if.frame_tick = 1'b0;
    exp_v = {OVER, 1'b0, 1'b1, 2'd0, 2'b11};
    n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL game_over: got %b expected %b", obs, exp_v); end
    gf_if.p1_dead = 1'b1; gf_if.p1_at_door = 1'b1; gf_if.p2_at_door = 1'b1;
    frames(3);
    gf_if.p1_dead = 1'b0; gf_if.p1_at_door = 1'b0; gf_if.p2_at_door = 1'b0;
    n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL over_ignores_inputs: got %b expected %b", obs, exp_v); end
    gf_if.start = 1'b1; step();
    exp_v = {IDLE, 1'b0, 1'b1, 2'd0, 2'b11};
    n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL over_to_idle: got %b expected %b", obs, exp_v); end
    step();
    n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL held_start_idle: got %b expected %b", obs, exp_v); end
    gf_if.start = 1'b0; step();
    gf_if.start = 1'b1; step();
    exp_v = {ARM, 1'b1, 1'b1, 2'd3, 2'b00};
    n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL restart_arm: got %b expected %b", obs, exp_v); end
    gf_if.start = 1'b0; step();
  endtask

  task automatic test_door();
    gf_if.p1_at_door = 1'b1; gf_if.p2_at_door = 1'b1;
    frames(29);
    exp_v = {PLAY, 1'b0, 1'b0, 2'd3, 2'b00};
    n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL door_29_play: got %b expected %b", obs, exp_v); end
    gf_if.p1_at_door = 1'b0; step(); gf_if.p1_at_door = 1'b1;
    frames(29);
    n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL door_restart_play: got %b expected %b", obs, exp_v); end
    gf_if.frame_tick = 1'b1; step(); gf_if.frame_tick = 1'b0;
    exp_v = {WIN, 1'b0, 1'b1, 2'd3, 2'b00};
    n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL door_win: got %b expected %b", obs, exp_v); end
    gf_if.p1_at_door = 1'b0; gf_if.p2_at_door = 1'b0;
    gf_if.start = 1'b1; step();
    exp_v = {IDLE, 1'b0, 1'b1, 2'd3, 2'b00};
    n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL win_to_idle: got %b expected %b", obs, exp_v); end
    gf_if.start = 1'b0; step();
    gf_if.start = 1'b1; step(); gf_if.start = 1'b0; step();
    exp_v = {PLAY, 1'b0, 1'b0, 2'd3, 2'b00};
    n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL win_replay: got %b expected %b", obs, exp_v); end
  endtask

  task automatic test_death_vs_win();
    gf_if.p1_at_door = 1'b1; gf_if.p2_at_door = 1'b1;
    frames(29);
    gf_if.p1_dead = 1'b1; gf_if.frame_tick = 1'b1; step();
    gf_if.p1_dead = 1'b0; gf_if.frame_tick = 1'b0;
    gf_if.p1_at_door = 1'b0; gf_if.p2_at_door = 1'b0;
    exp_v = {DYING, 1'b0, 1'b1, 2'd2, 2'b01};
    n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL death_beats_win: got %b expected %b", obs, exp_v); end
  endtask

  task automatic test_reset_mid_dying();
    frames(20);
    exp_v = {DYING, 1'b0, 1'b1, 2'd2, 2'b01};
    n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL dying_frame20: got %b expected %b", obs, exp_v); end
    gf_if.start = 1'b1; step();
    n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL dying_ignores_start: got %b expected %b", obs, exp_v); end
    Reset = 1'b1; step();
    exp_v = {IDLE, 1'b0, 1'b1, 2'd0, 2'b00};
    n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL reset_mid_dying: got %b expected %b", obs, exp_v); end
    gf_if.start = 1'b0; step();
    Reset = 1'b0; step(); step();
    n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL no_retrigger: got %b expected %b", obs, exp_v); end
    gf_if.start = 1'b1; step();
    exp_v = {ARM, 1'b1, 1'b1, 2'd3, 2'b00};
    n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL repress_arm: got %b expected %b", obs, exp_v); end
    gf_if.start = 1'b0; step();
  endtask

  task automatic test_start_through_reset();
    Reset = 1'b1; gf_if.start = 1'b1; step(); step();
    exp_v = {IDLE, 1'b0, 1'b1, 2'd0, 2'b00};
    n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL reset_priority: got %b expected %b", obs, exp_v); end
    Reset = 1'b0; step();
    exp_v = {ARM, 1'b1, 1'b1, 2'd3, 2'b00};
    n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL held_start_pulse: got %b expected %b", obs, exp_v); end
    step();
    exp_v = {PLAY, 1'b0, 1'b0, 2'd3, 2'b00};
    n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL held_start_play: got %b expected %b", obs, exp_v); end
    gf_if.start = 1'b0; step();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_start();
    test_death_p2();
    test_game_over();
    test_door();
    test_death_vs_win();
    test_reset_mid_dying();
    test_start_through_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
